// File: rtl/pcie_egress_collector.sv
// pcie_egress_collector: round-robin drain of egress FIFOs 4..7 into one valid/ready
// stream, with dest-field checking, per-port delivery counters and an error counter.
module pcie_egress_collector #(
   parameter int TAMANO_DATOS = 12,
   parameter int CNT_W        = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [3:0]              empty,
   input  logic [TAMANO_DATOS-1:0] data_in4,
   input  logic [TAMANO_DATOS-1:0] data_in5,
   input  logic [TAMANO_DATOS-1:0] data_in6,
   input  logic [TAMANO_DATOS-1:0] data_in7,
   output logic [3:0]              pop,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [TAMANO_DATOS-1:0] data_out,
   output logic [1:0]              out_port,
   output logic                    dest_error,
   input  logic [1:0]              idx,
   output logic [CNT_W-1:0]        cnt_out,
   output logic [CNT_W-1:0]        err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_WAIT = 2'd2,
      S_SEND = 2'd3
   } state_t;

   state_t                  state_q;
   logic [1:0]              sel_q;
   logic [1:0]              rr_ptr_q;
   logic [3:0]              pop_q;
   logic                    out_valid_q;
   logic [TAMANO_DATOS-1:0] data_out_q;
   logic [1:0]              out_port_q;
   logic                    dest_error_q;
   logic [CNT_W-1:0]        cnt_q [4];
   logic [CNT_W-1:0]        err_cnt_q;

   logic                    grant_vld_d;
   logic [1:0]              grant_sel_d;
   logic [TAMANO_DATOS-1:0] rd_data_s;
   logic                    dest_mismatch_s;

   // Returns {found, port}: first non-empty port at ptr, ptr+1, ... (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] empty_v, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + k[1:0];
         res  = empty_v[cand] ? res : {1'b1, cand};
      end
      return res;
   endfunction

   // Arbitration result and read-data mux for the port being served.
   always_comb begin
      {grant_vld_d, grant_sel_d} = rr_pick(empty, rr_ptr_q);
      case (sel_q)
         2'd0:    rd_data_s = data_in4;
         2'd1:    rd_data_s = data_in5;
         2'd2:    rd_data_s = data_in6;
         2'd3:    rd_data_s = data_in7;
         default: rd_data_s = data_in4;
      endcase
      dest_mismatch_s = (rd_data_s[9:8] != sel_q);
   end

   // Transaction FSM with all outputs and counters registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         sel_q        <= 2'd0;
         rr_ptr_q     <= 2'd0;
         pop_q        <= 4'b0000;
         out_valid_q  <= 1'b0;
         data_out_q   <= {TAMANO_DATOS{1'b0}};
         out_port_q   <= 2'd0;
         dest_error_q <= 1'b0;
         err_cnt_q    <= {CNT_W{1'b0}};
         for (int n = 0; n < 4; n++) begin
            cnt_q[n] <= {CNT_W{1'b0}};
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (enable && grant_vld_d) begin
                  sel_q   <= grant_sel_d;
                  pop_q   <= 4'b0001 << grant_sel_d;
                  state_q <= S_POP;
               end else begin
                  pop_q   <= 4'b0000;
               end
            end
            S_POP: begin
               // FIFO advances on this edge; its output is stable during WAIT.
               pop_q   <= 4'b0000;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               data_out_q   <= rd_data_s;
               out_port_q   <= sel_q;
               out_valid_q  <= 1'b1;
               dest_error_q <= dest_mismatch_s;
               if (dest_mismatch_s) begin
                  err_cnt_q <= err_cnt_q + CNT_W'(1);
               end
               state_q <= S_SEND;
            end
            S_SEND: begin
               dest_error_q <= 1'b0;
               if (out_ready) begin
                  out_valid_q  <= 1'b0;
                  cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
                  rr_ptr_q     <= sel_q + 2'd1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               pop_q   <= 4'b0000;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pop        = pop_q;
   assign out_valid  = out_valid_q;
   assign data_out   = data_out_q;
   assign out_port   = out_port_q;
   assign dest_error = dest_error_q;
   assign cnt_out    = cnt_q[idx];
   assign err_cnt    = err_cnt_q;

endmodule
